sim_console: RTL and testbench

Parametrised memory-mapped simulation console and control peripheral for the RS5 simulation environment, decoded in the 0x8 address region. Provides CHANNELS buffered character output streams with a valid/ready drain interface, a readable 64-bit cycle counter, an exit register and an inactivity watchdog. An end-of-simulation request is held off until every output FIFO has drained, then signalled on `done_o`.

---
 rtl/RS5_pkg.sv | 19 +
 rtl/sim_fifo.sv | 54 +++++
 rtl/sim_console.sv | 136 +++++++++++++
 tb/tb_sim_console.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// Shared constants for the RS5 simulation console: register offsets, state encoding
// and the exit code reported on watchdog expiry.
package RS5_pkg;

    localparam logic [11:0] OFF_EXIT     = 12'h000;
    localparam logic [11:0] OFF_CYCLE_LO = 12'h004;
    localparam logic [11:0] OFF_CYCLE_HI = 12'h008;
    localparam logic [11:0] OFF_STATUS   = 12'h00C;
    localparam logic [11:0] OFF_TXDATA   = 12'h100;

    localparam logic [31:0] TIMEOUT_EXIT_CODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CS_RUN   = 2'd0,
        CS_DRAIN = 2'd1,
        CS_DONE  = 2'd2
    } console_state_e;

endpackage

// File: rtl/sim_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
// A push while full and a pop while empty are both ignored.
module sim_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_n, rd_n;
    logic             do_push, do_pop;

    // Fullness is judged on the registered flag, so a same-cycle pop never frees room.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_n    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_n    = do_pop ? rd_q + PTR_ONE : rd_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wr_q  <= wr_n;
            rd_q  <= rd_n;
            empty <= (wr_n == rd_n);
            full  <= (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= din;
        end
    end

    assign head = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/sim_console.sv
// Memory-mapped simulation console: per-channel character FIFOs, 64-bit cycle counter,
// exit register and inactivity watchdog; done_o rises once every FIFO has drained.
module sim_console
    import RS5_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    // Reset value of the cycle counter; lets a run start close to a wrap boundary.
    parameter logic [63:0] CYCLE_INIT     = 64'd0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [11:0]           addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic [CHANNELS-1:0]   tx_valid_o,
    output logic [8*CHANNELS-1:0] tx_data_o,
    input  logic [CHANNELS-1:0]   tx_ready_i,
    output logic                  done_o,
    output logic [31:0]           exit_code_o,
    output logic                  timeout_o
);

    console_state_e state_q;
    logic [63:0]    cycle_q;
    logic [31:0]    shadow_q;
    logic [31:0]    wdog_q;
    logic [CHANNELS-1:0] ovf_q;

    logic [11:0]         addr_w;
    logic                wr, rd, exit_wr, status_rd, lo_rd, wdog_expire;
    logic [CHANNELS-1:0] push_req, push_acc, ovf_set, pop, full, empty;
    logic [7:0]          full8, ovf8;
    logic [31:0]         rdata_c;
    logic                unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign addr_w      = {addr_i[11:2], 2'b00};
    assign wr          = en_i && (we_i != 4'b0000);
    assign rd          = en_i && (we_i == 4'b0000);
    assign exit_wr     = wr && (addr_w == OFF_EXIT);
    assign status_rd   = rd && (addr_w == OFF_STATUS);
    assign lo_rd       = rd && (addr_w == OFF_CYCLE_LO);
    assign wdog_expire = (TIMEOUT_CYCLES != 0) && (state_q == CS_RUN)
                         && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        push_req = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            push_req[c] = wr && we_i[0] && (addr_w == OFF_TXDATA + 12'(4 * c));
        end
    end

    // Character writes only count while running; outside RUN they vanish silently.
    assign push_acc   = push_req & {CHANNELS{state_q == CS_RUN}};
    assign ovf_set    = push_acc & full;
    assign tx_valid_o = ~empty;
    assign pop        = tx_valid_o & tx_ready_i;
    assign full8      = 8'(full);
    assign ovf8       = 8'(ovf_q);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sim_fifo #(
            .WIDTH (8),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push_acc[c]),
            .pop     (pop[c]),
            .din     (data_i[7:0]),
            .full    (full[c]),
            .empty   (empty[c]),
            .head    (tx_data_o[8*c +: 8])
        );
    end

    always_comb begin
        rdata_c = '0;
        case (addr_w)
            OFF_CYCLE_LO: rdata_c = cycle_q[31:0];
            OFF_CYCLE_HI: rdata_c = shadow_q;
            OFF_STATUS:   rdata_c = {14'd0, state_q, ovf8, full8};
            default:      rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CS_RUN;
            cycle_q     <= CYCLE_INIT;
            shadow_q    <= '0;
            wdog_q      <= '0;
            ovf_q       <= '0;
            data_o      <= '0;
            done_o      <= 1'b0;
            exit_code_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            wdog_q  <= en_i ? '0 : wdog_q + 32'd1;
            if (rd) begin
                data_o <= rdata_c;
            end
            if (lo_rd) begin
                shadow_q <= cycle_q[63:32];
            end
            // A fresh overflow in the clearing cycle survives the read-clear.
            ovf_q <= (status_rd ? '0 : ovf_q) | ovf_set;

            case (state_q)
                CS_RUN: begin
                    if (exit_wr) begin
                        state_q     <= CS_DRAIN;
                        exit_code_o <= data_i;
                    end else if (wdog_expire) begin
                        state_q     <= CS_DRAIN;
                        exit_code_o <= TIMEOUT_EXIT_CODE;
                        timeout_o   <= 1'b1;
                    end
                end
                CS_DRAIN: begin
                    if (&empty) begin
                        state_q <= CS_DONE;
                        done_o  <= 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_console.sv
// Directed bench for sim_console: FIFO streaming, overflow, exit/drain, watchdog,
// cycle-counter snapshot across a 32-bit wrap, and reset during drain.
module tb_sim_console;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  tx_ready;

    logic [31:0] rdata, rdata2;
    logic [1:0]  tx_valid, tx_valid2;
    logic [15:0] tx_data, tx_data2;
    logic        done, done2;
    logic [31:0] exit_code, exit_code2;
    logic        timeout, timeout2;

    int n_cmp = 0;
    int n_bad = 0;

    sim_console #(
        .CHANNELS       (2),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (100),
        .CYCLE_INIT     (64'd0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (en),
        .we_i        (we),
        .addr_i      (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .done_o      (done),
        .exit_code_o (exit_code),
        .timeout_o   (timeout)
    );

    // Second instance starts its counter just below a 32-bit wrap and has no watchdog.
    sim_console #(
        .CHANNELS       (2),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (0),
        .CYCLE_INIT     (64'h0000_0000_FFFF_FFFE)
    ) dut_wrap (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (en),
        .we_i        (we),
        .addr_i      (addr),
        .data_i      (wdata),
        .data_o      (rdata2),
        .tx_valid_o  (tx_valid2),
        .tx_data_o   (tx_data2),
        .tx_ready_i  (tx_ready),
        .done_o      (done2),
        .exit_code_o (exit_code2),
        .timeout_o   (timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b0; we = '0; addr = '0; wdata = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] w);
        en = 1'b1; we = w; addr = a; wdata = d;
        tick();
        en = 1'b0; we = '0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d2);
        en = 1'b1; we = '0; addr = a;
        tick();
        en = 1'b0;
        d  = rdata;
        d2 = rdata2;
    endtask

    task automatic test_reset();
        logic [31:0] d, d2;
        tx_ready = 2'b00;
        do_reset();
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_data_o: got %h want %h", rdata, 32'h0); end
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL reset_tx_valid: got %b want %b", tx_valid, 2'b00); end
        n_cmp++; if ({done, timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_done_timeout: got %b want %b", {done, timeout}, 2'b00); end
        n_cmp++; if (exit_code !== 32'h0) begin n_bad++; $display("FAIL reset_exit_code: got %h want %h", exit_code, 32'h0); end
        bus_read(12'h004, d, d2);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_cycle_lo0: got %h want %h", d, 32'd0); end
        bus_read(12'h004, d, d2);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL reset_cycle_lo1: got %h want %h", d, 32'd1); end
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_cycle_wrap();
        logic [31:0] d, d2;
        do_reset();
        bus_read(12'h004, d, d2);
        n_cmp++; if (d2 !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL wrap_lo_pre: got %h want %h", d2, 32'hFFFF_FFFE); end
        bus_read(12'h008, d, d2);
        n_cmp++; if (d2 !== 32'h0) begin n_bad++; $display("FAIL wrap_hi_snapshot: got %h want %h", d2, 32'h0); end
        bus_read(12'h004, d, d2);
        n_cmp++; if (d2 !== 32'h0) begin n_bad++; $display("FAIL wrap_lo_wrapped: got %h want %h", d2, 32'h0); end
        bus_read(12'h008, d, d2);
        n_cmp++; if (d2 !== 32'h1) begin n_bad++; $display("FAIL wrap_hi_after: got %h want %h", d2, 32'h1); end
        bus_read(12'h010, d, d2);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_hello();
        tx_ready = 2'b11;
        bus_write(12'h100, 32'h48, 4'h1);
        n_cmp++; if (tx_valid !== 2'b01) begin n_bad++; $display("FAIL hello_valid_h: got %b want %b", tx_valid, 2'b01); end
        n_cmp++; if (tx_data[7:0] !== 8'h48) begin n_bad++; $display("FAIL hello_data_h: got %h want %h", tx_data[7:0], 8'h48); end
        bus_write(12'h100, 32'h69, 4'h1);
        n_cmp++; if (tx_valid !== 2'b01) begin n_bad++; $display("FAIL hello_valid_i: got %b want %b", tx_valid, 2'b01); end
        n_cmp++; if (tx_data[7:0] !== 8'h69) begin n_bad++; $display("FAIL hello_data_i: got %h want %h", tx_data[7:0], 8'h69); end
        tick();
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL hello_idle: got %b want %b", tx_valid, 2'b00); end
        bus_write(12'h104, 32'h77, 4'h2);
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL txdata_needs_we0: got %b want %b", tx_valid, 2'b00); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, d2;
        tx_ready = 2'b00;
        for (int i = 0; i < 17; i++) bus_write(12'h104, 32'(i + 1), 4'h1);
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0000_0202) begin n_bad++; $display("FAIL ovf_status1: got %h want %h", d, 32'h0000_0202); end
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0000_0002) begin n_bad++; $display("FAIL ovf_status2: got %h want %h", d, 32'h0000_0002); end
        tx_ready = 2'b10;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tx_valid[1] !== 1'b1 || tx_data[15:8] !== 8'(i + 1)) begin
                n_bad++; $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", i, tx_valid[1], tx_data[15:8], 8'(i + 1));
            end
            tick();
        end
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL ovf_drained: got %b want %b", tx_valid, 2'b00); end
        // Fill channel 0, then push while popping: the push must still be dropped.
        tx_ready = 2'b00;
        for (int i = 0; i < 16; i++) bus_write(12'h100, 32'(8'hA0 + i), 4'h1);
        tx_ready = 2'b01;
        bus_write(12'h100, 32'hEE, 4'h1);
        tx_ready = 2'b00;
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL full_pop_status: got %h want %h", d, 32'h0000_0100); end
        n_cmp++; if (tx_data[7:0] !== 8'hA1) begin n_bad++; $display("FAIL full_pop_head: got %h want %h", tx_data[7:0], 8'hA1); end
        tx_ready = 2'b01;
        repeat (15) tick();
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL full_pop_count: got %b want %b", tx_valid, 2'b00); end
    endtask

    task automatic test_exit();
        logic [31:0] d, d2;
        tx_ready = 2'b00;
        bus_write(12'h100, 32'h61, 4'h1);
        bus_write(12'h100, 32'h62, 4'h1);
        bus_write(12'h100, 32'h63, 4'h1);
        bus_write(12'h000, 32'h2A, 4'hF);
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL exit_status_drain: got %h want %h", d, 32'h0001_0000); end
        tx_ready = 2'b01;
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL exit_done_early1: got %b want %b", done, 1'b0); end
        tick();
        tick();
        n_cmp++; if ({done, tx_valid} !== 3'b000) begin n_bad++; $display("FAIL exit_after_pop3: got %b want %b", {done, tx_valid}, 3'b000); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL exit_done: got %b want %b", done, 1'b1); end
        n_cmp++; if (exit_code !== 32'h2A) begin n_bad++; $display("FAIL exit_code: got %h want %h", exit_code, 32'h2A); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL exit_timeout: got %b want %b", timeout, 1'b0); end
        bus_write(12'h000, 32'h55, 4'hF);
        n_cmp++; if (exit_code !== 32'h2A) begin n_bad++; $display("FAIL exit_second_ignored: got %h want %h", exit_code, 32'h2A); end
        tx_ready = 2'b00;
        bus_write(12'h104, 32'h33, 4'h1);
        n_cmp++; if (tx_valid !== 2'b00) begin n_bad++; $display("FAIL done_tx_dropped: got %b want %b", tx_valid, 2'b00); end
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0002_0000) begin n_bad++; $display("FAIL done_status: got %h want %h", d, 32'h0002_0000); end
    endtask

    task automatic test_reset_drain();
        logic [31:0] d, d2;
        do_reset();
        tx_ready = 2'b00;
        bus_write(12'h104, 32'h11, 4'h1);
        bus_write(12'h104, 32'h22, 4'h1);
        bus_write(12'h000, 32'h7, 4'hF);
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL rdrain_status: got %h want %h", d, 32'h0001_0000); end
        do_reset();
        n_cmp++; if ({tx_valid, done} !== 3'b000) begin n_bad++; $display("FAIL rdrain_outputs: got %b want %b", {tx_valid, done}, 3'b000); end
        n_cmp++; if (exit_code !== 32'h0) begin n_bad++; $display("FAIL rdrain_exit: got %h want %h", exit_code, 32'h0); end
        bus_read(12'h00C, d, d2);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rdrain_run: got %h want %h", d, 32'h0); end
        bus_write(12'h104, 32'h99, 4'h1);
        n_cmp++; if (tx_data[15:8] !== 8'h99) begin n_bad++; $display("FAIL rdrain_fresh_head: got %h want %h", tx_data[15:8], 8'h99); end
    endtask

    task automatic test_watchdog();
        tx_ready = 2'b00;
        do_reset();
        repeat (99) tick();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL wdog_early: got %b want %b", timeout, 1'b0); end
        tick();
        n_cmp++; if ({timeout, done} !== 2'b10) begin n_bad++; $display("FAIL wdog_drain: got %b want %b", {timeout, done}, 2'b10); end
        n_cmp++; if (exit_code !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wdog_code: got %h want %h", exit_code, 32'hFFFF_FFFF); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wdog_done: got %b want %b", done, 1'b1); end
        n_cmp++; if ({timeout2, done2} !== 2'b00) begin n_bad++; $display("FAIL wdog_disabled: got %b want %b", {timeout2, done2}, 2'b00); end
    endtask

    task automatic test_keepalive();
        logic [31:0] d, d2;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            repeat (49) tick();
            bus_read(12'h00C, d, d2);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL keepalive%0d: got %h want %h", k, d, 32'h0); end
        end
        n_cmp++; if ({timeout, done} !== 2'b00) begin n_bad++; $display("FAIL keepalive_final: got %b want %b", {timeout, done}, 2'b00); end
    endtask

    task automatic test_exit_vs_wdog();
        do_reset();
        repeat (99) tick();
        bus_write(12'h000, 32'h1234_5678, 4'hF);
        n_cmp++; if (exit_code !== 32'h1234_5678) begin n_bad++; $display("FAIL race_code: got %h want %h", exit_code, 32'h1234_5678); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL race_timeout: got %b want %b", timeout, 1'b0); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL race_done: got %b want %b", done, 1'b1); end
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; we = '0; addr = '0; wdata = '0; tx_ready = '0;
        test_reset();
        test_cycle_wrap();
        test_hello();
        test_overflow();
        test_exit();
        test_reset_drain();
        test_watchdog();
        test_keepalive();
        test_exit_vs_wdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
